am_demod_sched: RTL and testbench

Round-robin scheduler that time-shares one pipelined AM magnitude core (the `am_demod` datapath) between `NUM_CH` I/Q requesters. It sits between the per-channel channelizer outputs and the single demodulator instance. It grants at most one channel per clock and registers the chosen sample into the core. It then carries a channel tag through a latency-matched shift register and steers each core result back out with its channel index. It also checks that core output timing matches the expected latency.

---
 rtl/am_demod_sched_if.sv | 36 +++
 rtl/am_demod_sched.sv | 116 +++++++++++
 tb/tb_am_demod_sched.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/am_demod_sched_if.sv
`default_nettype none
// am_demod_sched_if: requester, core and result signals of the AM demod scheduler.
// Rev 1.0 - initial release
interface am_demod_sched_if #(
  parameter int DATA_WIDTH = 12,
  parameter int NUM_CH     = 4,
  parameter int CH_W       = $clog2(NUM_CH)
);
  logic [NUM_CH-1:0]            ch_enable;
  logic [NUM_CH-1:0]            ch_valid;
  logic [NUM_CH-1:0]            ch_ready;
  logic [NUM_CH*DATA_WIDTH-1:0] ch_inphase;
  logic [NUM_CH*DATA_WIDTH-1:0] ch_quadrature;
  logic                         core_valid;
  logic [DATA_WIDTH-1:0]        core_inphase;
  logic [DATA_WIDTH-1:0]        core_quadrature;
  logic                         core_demod_valid;
  logic [DATA_WIDTH-1:0]        core_demod;
  logic                         out_valid;
  logic [CH_W-1:0]              out_ch;
  logic [DATA_WIDTH-1:0]        out_demod;
  logic                         sync_err;

  modport slave (
    input  ch_enable, ch_valid, ch_inphase, ch_quadrature, core_demod_valid, core_demod,
    output ch_ready, core_valid, core_inphase, core_quadrature, out_valid, out_ch, out_demod,
           sync_err
  );

  modport master (
    output ch_enable, ch_valid, ch_inphase, ch_quadrature, core_demod_valid, core_demod,
    input  ch_ready, core_valid, core_inphase, core_quadrature, out_valid, out_ch, out_demod,
           sync_err
  );
endinterface
`default_nettype wire

// File: rtl/am_demod_sched.sv
`default_nettype none
// am_demod_sched: round-robin sharing of one pipelined AM magnitude core among NUM_CH requesters.
// Rev 1.0 - initial release
module am_demod_sched #(
  parameter int DATA_WIDTH   = 12,
  parameter int NUM_CH       = 4,
  parameter int CORE_LATENCY = 5
) (
  input  logic             clk,
  input  logic             arst,
  am_demod_sched_if.slave  bus
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [CH_W-1:0]       r_last_grant;
  logic [NUM_CH-1:0]     w_cand;
  logic [NUM_CH-1:0]     w_grant;
  logic [CH_W-1:0]       w_grant_idx;
  logic                  w_grant_any;
  logic                  w_xfer;
  logic [DATA_WIDTH-1:0] w_sel_i;
  logic [DATA_WIDTH-1:0] w_sel_q;

  logic                  r_core_valid;
  logic [DATA_WIDTH-1:0] r_core_i;
  logic [DATA_WIDTH-1:0] r_core_q;
  logic [CH_W-1:0]       r_issue_idx;
  logic                  r_tag_v  [CORE_LATENCY];
  logic [CH_W-1:0]       r_tag_ch [CORE_LATENCY];
  logic                  w_tail_v;
  logic [CH_W-1:0]       w_tail_ch;

  logic                  r_out_valid;
  logic [CH_W-1:0]       r_out_ch;
  logic [DATA_WIDTH-1:0] r_out_demod;
  logic                  r_sync_err;

  // Walk offsets from farthest to nearest so the nearest candidate after last_grant wins.
  always_comb begin
    int              w_idx;
    logic [CH_W-1:0] w_idx_c;
    w_cand      = bus.ch_valid & bus.ch_enable;
    w_grant     = '0;
    w_grant_idx = '0;
    w_grant_any = 1'b0;
    for (int s = NUM_CH; s >= 1; s--) begin
      w_idx   = (int'(r_last_grant) + s) % NUM_CH;
      w_idx_c = CH_W'(w_idx);
      if (w_cand[w_idx_c]) begin
        w_grant              = '0;
        w_grant[w_idx_c]     = 1'b1;
        w_grant_idx          = w_idx_c;
        w_grant_any          = 1'b1;
      end
    end
  end

  assign bus.ch_ready = arst ? '0 : w_grant;
  assign w_xfer       = w_grant_any & ~arst;
  assign w_sel_i      = bus.ch_inphase[int'(w_grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign w_sel_q      = bus.ch_quadrature[int'(w_grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign w_tail_v     = r_tag_v[CORE_LATENCY-1];
  assign w_tail_ch    = r_tag_ch[CORE_LATENCY-1];

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_last_grant <= CH_W'(NUM_CH - 1);
      r_core_valid <= 1'b0;
      r_core_i     <= '0;
      r_core_q     <= '0;
      r_issue_idx  <= '0;
      for (int k = 0; k < CORE_LATENCY; k++) begin
        r_tag_v[k]  <= 1'b0;
        r_tag_ch[k] <= '0;
      end
      r_out_valid  <= 1'b0;
      r_out_ch     <= '0;
      r_out_demod  <= '0;
      r_sync_err   <= 1'b0;
    end else begin
      r_core_valid <= w_xfer;
      if (w_xfer) begin
        r_last_grant <= w_grant_idx;
        r_issue_idx  <= w_grant_idx;
        r_core_i     <= w_sel_i;
        r_core_q     <= w_sel_q;
      end

      r_tag_v[0]  <= r_core_valid;
      r_tag_ch[0] <= r_issue_idx;
      for (int k = 1; k < CORE_LATENCY; k++) begin
        r_tag_v[k]  <= r_tag_v[k-1];
        r_tag_ch[k] <= r_tag_ch[k-1];
      end

      // A result is only forwarded when the core and the tag pipe agree.
      r_out_valid <= bus.core_demod_valid & w_tail_v;
      if (bus.core_demod_valid & w_tail_v) begin
        r_out_ch    <= w_tail_ch;
        r_out_demod <= bus.core_demod;
      end
      if (bus.core_demod_valid != w_tail_v) begin
        r_sync_err <= 1'b1;
      end
    end
  end

  assign bus.core_valid      = r_core_valid;
  assign bus.core_inphase    = r_core_i;
  assign bus.core_quadrature = r_core_q;
  assign bus.out_valid       = r_out_valid;
  assign bus.out_ch          = r_out_ch;
  assign bus.out_demod       = r_out_demod;
  assign bus.sync_err        = r_sync_err;
endmodule
`default_nettype wire

// File: tb/tb_am_demod_sched.sv
`default_nettype none
// tb_am_demod_sched: directed bench for am_demod_sched with a behavioural magnitude core.
// Rev 1.0 - initial release
`timescale 1ns/1ps
module tb_am_demod_sched;
  localparam int DW  = 12;
  localparam int NCH = 4;
  localparam int LAT = 5;

  logic clk  = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  am_demod_sched_if #(.DATA_WIDTH(DW), .NUM_CH(NCH)) bus();

  am_demod_sched #(.DATA_WIDTH(DW), .NUM_CH(NCH), .CORE_LATENCY(LAT)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  // Behavioural core with selectable latency.
  int              model_lat = LAT;
  logic            mv [8];
  logic [DW-1:0]   md [8];

  function automatic logic [DW-1:0] mag(input logic signed [DW-1:0] i, input logic signed [DW-1:0] q);
    int v, r;
    v = int'(i) * int'(i) + int'(q) * int'(q);
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return DW'(r);
  endfunction

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int k = 0; k < 8; k++) begin
        mv[k] <= 1'b0;
        md[k] <= '0;
      end
    end else begin
      mv[0] <= bus.core_valid;
      md[0] <= mag(bus.core_inphase, bus.core_quadrature);
      for (int k = 1; k < 8; k++) begin
        mv[k] <= mv[k-1];
        md[k] <= md[k-1];
      end
    end
  end

  assign bus.core_demod_valid = mv[model_lat-1];
  assign bus.core_demod       = md[model_lat-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int due;
    int ch;
    int demod;
  } exp_t;
  exp_t sbq[$];

  always @(negedge clk) begin
    exp_t e;
    if (bus.out_valid) begin
      if (sbq.size() == 0) begin
        check("unexpected out_valid", int'(bus.out_valid), 0);
      end else begin
        e = sbq.pop_front();
        check("out_cycle", cyc, e.due);
        check("out_ch", int'(bus.out_ch), e.ch);
        check("out_demod", int'(bus.out_demod), e.demod);
      end
    end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      check("missing out_valid", int'(bus.out_valid), 1);
    end
  end

  function automatic int oh2idx(input logic [NCH-1:0] oh);
    int r;
    r = 0;
    for (int k = 0; k < NCH; k++) if (oh[k]) r = k;
    return r;
  endfunction

  task automatic drive(input logic [NCH-1:0] en, input logic [NCH-1:0] vld, input int ib, input int q);
    bus.ch_enable = en;
    bus.ch_valid  = vld;
    for (int k = 0; k < NCH; k++) begin
      bus.ch_inphase[k*DW +: DW]    = DW'(ib + k);
      bus.ch_quadrature[k*DW +: DW] = DW'(q);
    end
  endtask

  task automatic push(input int ch, input int demod);
    exp_t e;
    e.due   = cyc + 2 + LAT;
    e.ch    = ch;
    e.demod = demod;
    sbq.push_back(e);
  endtask

  typedef struct {
    logic [NCH-1:0] en;
    logic [NCH-1:0] vld;
    int             ib;
    int             q;
    logic [NCH-1:0] rdy;
    int             demod;
  } vec_t;
  vec_t vt[15];

  initial begin
    bit prev_any;
    int prev_i;
    int stale;

    // Channel k carries I = ib + k, Q = q; demod is the hand-computed magnitude of the granted channel.
    vt[0]  = '{4'hF, 4'h1,   3,  4, 4'h1,  5};
    vt[1]  = '{4'hF, 4'h1,  -5, 12, 4'h1, 13};
    vt[2]  = '{4'hF, 4'hF,  10,  0, 4'h2, 11};
    vt[3]  = '{4'hF, 4'hF,  10,  0, 4'h4, 12};
    vt[4]  = '{4'hF, 4'hF, -20,  0, 4'h8, 17};
    vt[5]  = '{4'hF, 4'hF,   7,  0, 4'h1,  7};
    vt[6]  = '{4'hA, 4'hF,   1,  0, 4'h2,  2};
    vt[7]  = '{4'hA, 4'hF,   1,  0, 4'h8,  4};
    vt[8]  = '{4'hA, 4'hF,   0,  0, 4'h2,  1};
    vt[9]  = '{4'hF, 4'h0,   0,  0, 4'h0,  0};
    vt[10] = '{4'hF, 4'h9,   5,  0, 4'h8,  8};
    vt[11] = '{4'hF, 4'h9,   5,  0, 4'h1,  5};
    vt[12] = '{4'h0, 4'hF,   0,  0, 4'h0,  0};
    vt[13] = '{4'hF, 4'h5,   2,  0, 4'h4,  4};
    vt[14] = '{4'hF, 4'h3,   6,  8, 4'h1, 10};

    drive(4'hF, 4'hF, 0, 0);
    arst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset ch_ready", int'(bus.ch_ready), 0);
    check("reset core_valid", int'(bus.core_valid), 0);
    check("reset core_inphase", int'(bus.core_inphase), 0);
    check("reset out_valid", int'(bus.out_valid), 0);
    check("reset sync_err", int'(bus.sync_err), 0);
    drive(4'hF, 4'h0, 0, 0);
    arst = 1'b0;

    // Table-driven arbitration sequence starting from last_grant = NUM_CH-1.
    prev_any = 1'b0;
    prev_i   = 0;
    for (int r = 0; r < 15; r++) begin
      @(negedge clk);
      check("core_valid", int'(bus.core_valid), int'(prev_any));
      if (prev_any) check("core_inphase", int'($signed(bus.core_inphase)), prev_i);
      drive(vt[r].en, vt[r].vld, vt[r].ib, vt[r].q);
      #1;
      check("ch_ready", int'(bus.ch_ready), int'(vt[r].rdy));
      prev_any = (vt[r].rdy != '0);
      if (prev_any) begin
        prev_i = vt[r].ib + oh2idx(vt[r].rdy);
        push(oh2idx(vt[r].rdy), vt[r].demod);
      end
    end
    @(negedge clk);
    check("core_valid last", int'(bus.core_valid), int'(prev_any));
    drive(4'hF, 4'h0, 0, 0);
    repeat (10) @(negedge clk);
    check("table drained", sbq.size(), 0);

    // Reset with three samples in flight; pointer left at 1 must return to NUM_CH-1.
    for (int k = 0; k < 3; k++) begin
      drive(4'hF, 4'h3, 1, 0);
      @(negedge clk);
    end
    arst = 1'b1;
    drive(4'hF, 4'hF, 0, 0);
    sbq.delete();
    repeat (2) @(negedge clk);
    check("mid reset ch_ready", int'(bus.ch_ready), 0);
    check("mid reset core_valid", int'(bus.core_valid), 0);
    check("mid reset out_valid", int'(bus.out_valid), 0);
    drive(4'hF, 4'h0, 0, 0);
    arst = 1'b0;
    stale = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    check("stale out_valid count", stale, 0);
    check("post reset out_ch", int'(bus.out_ch), 0);
    check("post reset out_demod", int'(bus.out_demod), 0);

    // Round-robin: all channels valid for 12 cycles, channel k sends I = k+1, Q = 0.
    for (int k = 0; k < 12; k++) begin
      drive(4'hF, 4'hF, 1, 0);
      #1;
      check("rr ch_ready", int'(bus.ch_ready), 1 << (k % NCH));
      push(k % NCH, (k % NCH) + 1);
      @(negedge clk);
    end
    drive(4'hF, 4'h0, 0, 0);
    repeat (10) @(negedge clk);
    check("rr drained", sbq.size(), 0);

    // Single channel 2 with I=3, Q=4.
    drive(4'hF, 4'h4, 1, 4);
    #1;
    check("single ch_ready", int'(bus.ch_ready), 4);
    push(2, 5);
    @(negedge clk);
    drive(4'hF, 4'h0, 0, 0);
    check("single core_valid", int'(bus.core_valid), 1);
    check("single core_inphase", int'(bus.core_inphase), 3);
    check("single core_quadrature", int'(bus.core_quadrature), 4);
    @(negedge clk);
    check("single core_valid drop", int'(bus.core_valid), 0);
    repeat (10) @(negedge clk);
    check("single drained", sbq.size(), 0);
    check("sync_err clean", int'(bus.sync_err), 0);

    // Core one cycle too fast: sticky sync error, no results forwarded.
    model_lat = 4;
    drive(4'hF, 4'h2, 0, 0);
    @(negedge clk);
    drive(4'hF, 4'h0, 0, 0);
    repeat (8) @(negedge clk);
    check("sync_err set", int'(bus.sync_err), 1);
    for (int k = 0; k < 3; k++) begin
      drive(4'hF, 4'h1, 2, 0);
      @(negedge clk);
      drive(4'hF, 4'h0, 0, 0);
      repeat (2) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    check("sync_err sticky", int'(bus.sync_err), 1);
    arst = 1'b1;
    @(negedge clk);
    check("sync_err in reset", int'(bus.sync_err), 0);
    model_lat = LAT;
    arst = 1'b0;
    repeat (3) @(negedge clk);
    check("sync_err after reset", int'(bus.sync_err), 0);
    check("final drained", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
